// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: default parameters,
// FSM state encoding, bus widths and small address helpers.
package dmem_pkg;

  localparam int DEPTH_WORDS_DEF  = 32;
  localparam int DBG_MAX_WAIT_DEF = 4;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  // state   | meaning
  // S_IDLE  | serve CPU requests, arbitrate debug requests
  // S_ACK   | one-cycle debug acknowledge, dbg_req ignored
  typedef enum logic {
    S_IDLE = 1'b0,
    S_ACK  = 1'b1
  } state_t;

  // One memory-side access as selected by the arbiter.
  typedef struct packed {
    logic              read;
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_acc_t;

  // Word index of a byte address.
  function automatic logic [ADDR_W-1:0] word_index(input logic [ADDR_W-1:0] addr);
    return addr >> 2;
  endfunction

  // True when the byte address is word aligned.
  function automatic logic is_aligned(input logic [ADDR_W-1:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle for the data-memory arbiter: CPU port, debug port,
// memory port and the sticky address-error flag.
interface dmem_arbiter_if;
  import dmem_pkg::*;

  // CPU side
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;

  // Debug side
  logic              dbg_req;
  logic              dbg_we;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic [DATA_W-1:0] dbg_rdata;
  logic              dbg_ack;

  // Memory side (asynchronous read, write on the clock edge)
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_write;
  logic              mem_read;
  logic [DATA_W-1:0] mem_rdata;

  // Sticky error
  logic              addr_err;

  // The arbiter itself
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  mem_rdata,
    output cpu_rdata, cpu_stall,
    output dbg_rdata, dbg_ack,
    output mem_addr, mem_wdata, mem_write, mem_read,
    output addr_err
  );

  // The environment driving requests and providing the memory
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output mem_rdata,
    input  cpu_rdata, cpu_stall,
    input  dbg_rdata, dbg_ack,
    input  mem_addr, mem_wdata, mem_write, mem_read,
    input  addr_err
  );

endinterface

// File: rtl/dmem_addr_chk.sv
// Address validity check: a request is valid only when word aligned and
// inside the DEPTH_WORDS-word memory window.
module dmem_addr_chk
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = DEPTH_WORDS_DEF
) (
  input  logic [ADDR_W-1:0] addr,
  output logic              valid
);

  localparam logic [ADDR_W-1:0] DEPTH_LIM = ADDR_W'(DEPTH_WORDS);

  logic in_range;

  // Alignment and range are independent; both must hold.
  always_comb begin
    in_range = (word_index(addr) < DEPTH_LIM);
    valid    = is_aligned(addr) && in_range;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbiter sharing one data memory between the CPU and a debug port.
// The CPU is served combinationally in the same cycle; the debug port is
// granted when the CPU is idle or after it has waited DBG_MAX_WAIT cycles,
// and is acknowledged one cycle after its grant.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS  = DEPTH_WORDS_DEF,
  parameter int DBG_MAX_WAIT = DBG_MAX_WAIT_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  dmem_arbiter_if.slave  bus
);

  // Keep the counter at least one bit wide even for a zero wait limit.
  localparam int WCW = (DBG_MAX_WAIT > 0) ? $clog2(DBG_MAX_WAIT + 1) : 1;
  localparam logic [WCW-1:0] WAIT_MAX = WCW'(DBG_MAX_WAIT);

  state_t            state;
  state_t            state_nxt;
  logic [WCW-1:0]    wait_cnt;
  logic [WCW-1:0]    wait_cnt_nxt;
  logic              dbg_gnt;
  logic              cpu_srv;
  logic              cpu_valid;
  logic              dbg_valid;
  logic [DATA_W-1:0] cpu_rd_val;
  logic [DATA_W-1:0] dbg_rd_val;
  logic [DATA_W-1:0] cpu_rdata_q;
  logic [DATA_W-1:0] dbg_rdata_q;
  logic              addr_err_q;
  logic              err_now;
  mem_acc_t          acc;

  dmem_addr_chk #(.DEPTH_WORDS(DEPTH_WORDS)) u_chk_cpu (
    .addr  (bus.cpu_addr),
    .valid (cpu_valid)
  );

  dmem_addr_chk #(.DEPTH_WORDS(DEPTH_WORDS)) u_chk_dbg (
    .addr  (bus.dbg_addr),
    .valid (dbg_valid)
  );

  // Next state and debug grant; dbg_req is only looked at in S_IDLE.
  always_comb begin
    state_nxt = state;
    dbg_gnt   = 1'b0;
    case (state)
      S_IDLE: begin
        dbg_gnt = bus.dbg_req && (!bus.cpu_req || (wait_cnt == WAIT_MAX));
        if (dbg_gnt) begin
          state_nxt = S_ACK;
        end
      end
      S_ACK: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Debug wait counter: counts refused cycles, saturates, clears on grant or drop.
  always_comb begin
    wait_cnt_nxt = '0;
    if ((state == S_IDLE) && bus.dbg_req && !dbg_gnt) begin
      wait_cnt_nxt = (wait_cnt == WAIT_MAX) ? wait_cnt : wait_cnt + 1'b1;
    end
  end

  // Memory port mux: debug wins when granted, otherwise the CPU if requesting.
  always_comb begin
    acc     = '0;
    cpu_srv = bus.cpu_req && !dbg_gnt;
    if (dbg_gnt) begin
      acc.addr  = bus.dbg_addr;
      acc.wdata = bus.dbg_wdata;
      acc.read  = !bus.dbg_we;
      acc.write = bus.dbg_we && dbg_valid;
    end else if (cpu_srv) begin
      acc.addr  = bus.cpu_addr;
      acc.wdata = bus.cpu_wdata;
      acc.read  = !bus.cpu_we;
      acc.write = bus.cpu_we && cpu_valid;
    end
    // A write must never reach the memory while reset is asserted.
    if (!rst_n) begin
      acc.write = 1'b0;
    end
  end

  // Drive the memory port from the selected access.
  always_comb begin
    bus.mem_addr  = acc.addr;
    bus.mem_wdata = acc.wdata;
    bus.mem_read  = acc.read;
    bus.mem_write = acc.write;
  end

  // Read data seen by each port; invalid addresses read as zero.
  always_comb begin
    cpu_rd_val = cpu_valid ? bus.mem_rdata : '0;
    dbg_rd_val = dbg_valid ? bus.mem_rdata : '0;
    err_now    = (bus.cpu_req && !cpu_valid) || (dbg_gnt && !dbg_valid);
  end

  // CPU-facing outputs: pass-through on a served read, held value otherwise.
  always_comb begin
    bus.cpu_stall = bus.cpu_req && dbg_gnt;
    bus.cpu_rdata = (cpu_srv && !bus.cpu_we) ? cpu_rd_val : cpu_rdata_q;
  end

  // Debug-facing outputs and the sticky error flag.
  always_comb begin
    bus.dbg_ack   = (state == S_ACK);
    bus.dbg_rdata = dbg_rdata_q;
    bus.addr_err  = addr_err_q;
  end

  // FSM state and wait counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  // Read-data hold registers for both ports.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
    end else begin
      if (cpu_srv && !bus.cpu_we) begin
        cpu_rdata_q <= cpu_rd_val;
      end
      if (dbg_gnt && !bus.dbg_we) begin
        dbg_rdata_q <= dbg_rd_val;
      end
    end
  end

  // Sticky address error, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_err_q <= 1'b0;
    end else if (err_now) begin
      addr_err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small behavioural data memory.
module tb_dmem_arbiter;
  import dmem_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;
  int   gnt_cyc;
  logic [31:0] tmem [64];

  dmem_arbiter_if bus ();

  dmem_arbiter #(.DEPTH_WORDS(32), .DBG_MAX_WAIT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Memory model: 64 words so out-of-window addresses still return data.
  always_comb bus.mem_rdata = tmem[bus.mem_addr[7:2]];

  always @(posedge clk) begin
    if (bus.mem_write) tmem[bus.mem_addr[7:2]] <= bus.mem_wdata;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.dbg_req = 1'b0; bus.dbg_we = 1'b0; bus.dbg_addr = '0; bus.dbg_wdata = '0;
  endtask

  task automatic cpu_drive(input logic we, input logic [31:0] addr, input logic [31:0] wd);
    bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wd;
  endtask

  task automatic dbg_drive(input logic we, input logic [31:0] addr, input logic [31:0] wd);
    bus.dbg_req = 1'b1; bus.dbg_we = we; bus.dbg_addr = addr; bus.dbg_wdata = wd;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) tmem[i] = '0;
    tmem[32] = 32'hBAD0_BAD0;
    idle_all();
    rst_n = 1'b0;

    // Reset: a CPU write request must not reach memory, state cleared.
    cpu_drive(1'b1, 32'h8, 32'h5555_5555);
    step(); step();
    @(negedge clk);
    chk("rst_mem_write", {31'b0, bus.mem_write}, 32'd0);
    chk("rst_dbg_ack", {31'b0, bus.dbg_ack}, 32'd0);
    chk("rst_dbg_rdata", bus.dbg_rdata, 32'd0);
    chk("rst_cpu_rdata", bus.cpu_rdata, 32'd0);
    chk("rst_addr_err", {31'b0, bus.addr_err}, 32'd0);
    chk("rst_no_write", tmem[2], 32'd0);
    step();
    rst_n = 1'b1;
    idle_all();
    @(negedge clk);
    chk("idle_mem_read", {31'b0, bus.mem_read}, 32'd0);
    chk("idle_mem_write", {31'b0, bus.mem_write}, 32'd0);

    // CPU write then read of 0x8.
    step();
    cpu_drive(1'b1, 32'h8, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("cpu_wr_mem_write", {31'b0, bus.mem_write}, 32'd1);
    chk("cpu_wr_addr", bus.mem_addr, 32'h8);
    chk("cpu_wr_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
    chk("cpu_wr_stall", {31'b0, bus.cpu_stall}, 32'd0);
    step();
    cpu_drive(1'b0, 32'h8, 32'h0);
    @(negedge clk);
    chk("cpu_rd_mem_write", {31'b0, bus.mem_write}, 32'd0);
    chk("cpu_rd_mem_read", {31'b0, bus.mem_read}, 32'd1);
    chk("cpu_rd_data", bus.cpu_rdata, 32'hDEAD_BEEF);
    chk("cpu_rd_stall", {31'b0, bus.cpu_stall}, 32'd0);
    step();
    idle_all();
    @(negedge clk);
    chk("cpu_rd_hold", bus.cpu_rdata, 32'hDEAD_BEEF);
    chk("cpu_idle_read", {31'b0, bus.mem_read}, 32'd0);

    // Debug read of 0x8 with the CPU idle; held request not regranted in S_ACK.
    step();
    dbg_drive(1'b0, 32'h8, 32'h0);
    @(negedge clk);
    chk("dbg_rd_gnt_read", {31'b0, bus.mem_read}, 32'd1);
    chk("dbg_rd_gnt_addr", bus.mem_addr, 32'h8);
    chk("dbg_rd_c0_ack", {31'b0, bus.dbg_ack}, 32'd0);
    step();
    @(negedge clk);
    chk("dbg_rd_c1_ack", {31'b0, bus.dbg_ack}, 32'd1);
    chk("dbg_rd_c1_data", bus.dbg_rdata, 32'hDEAD_BEEF);
    chk("dbg_rd_c1_nogrant", {31'b0, bus.mem_read}, 32'd0);
    step();
    idle_all();
    @(negedge clk);
    chk("dbg_rd_c2_ack", {31'b0, bus.dbg_ack}, 32'd0);
    chk("dbg_rd_c2_hold", bus.dbg_rdata, 32'hDEAD_BEEF);

    // Debug write of 0x10, then CPU reads it back.
    step();
    dbg_drive(1'b1, 32'h10, 32'h1234_5678);
    @(negedge clk);
    chk("dbg_wr_mem_write", {31'b0, bus.mem_write}, 32'd1);
    chk("dbg_wr_addr", bus.mem_addr, 32'h10);
    step();
    idle_all();
    @(negedge clk);
    chk("dbg_wr_ack", {31'b0, bus.dbg_ack}, 32'd1);
    chk("dbg_wr_rdata_hold", bus.dbg_rdata, 32'hDEAD_BEEF);
    step();
    cpu_drive(1'b0, 32'h10, 32'h0);
    @(negedge clk);
    chk("cpu_rd_dbgwr", bus.cpu_rdata, 32'h1234_5678);
    step();
    idle_all();

    // Starvation: CPU held, debug raised together; CPU wins until cycle 4.
    cpu_drive(1'b0, 32'h8, 32'h0);
    dbg_drive(1'b0, 32'h10, 32'h0);
    for (int c = 0; c < 6; c++) begin
      if (c == 5) bus.dbg_req = 1'b0;
      @(negedge clk);
      chk($sformatf("starve_c%0d_stall", c), {31'b0, bus.cpu_stall}, {31'b0, (c == 4)});
      chk($sformatf("starve_c%0d_ack", c), {31'b0, bus.dbg_ack}, {31'b0, (c == 5)});
      chk($sformatf("starve_c%0d_addr", c), bus.mem_addr, (c == 4) ? 32'h10 : 32'h8);
      step();
    end
    chk("starve_dbg_rdata", bus.dbg_rdata, 32'h1234_5678);
    idle_all();

    // Address errors: misaligned CPU write, misaligned read, out-of-range debug read.
    cpu_drive(1'b1, 32'h6, 32'hCAFE_F00D);
    @(negedge clk);
    chk("err_wr_mem_write", {31'b0, bus.mem_write}, 32'd0);
    chk("err_wr_flag_early", {31'b0, bus.addr_err}, 32'd0);
    step();
    cpu_drive(1'b0, 32'h9, 32'h0);
    @(negedge clk);
    chk("err_flag_set", {31'b0, bus.addr_err}, 32'd1);
    chk("err_wr_no_store", tmem[1], 32'd0);
    chk("err_cpu_rd_zero", bus.cpu_rdata, 32'd0);
    step();
    idle_all();
    dbg_drive(1'b0, 32'h80, 32'h0);
    @(negedge clk);
    chk("err_dbg_mem_write", {31'b0, bus.mem_write}, 32'd0);
    chk("err_dbg_granted", {31'b0, bus.mem_read}, 32'd1);
    step();
    idle_all();
    @(negedge clk);
    chk("err_dbg_ack", {31'b0, bus.dbg_ack}, 32'd1);
    chk("err_dbg_rd_zero", bus.dbg_rdata, 32'd0);
    step(); step();
    @(negedge clk);
    chk("err_flag_sticky", {31'b0, bus.addr_err}, 32'd1);

    // Reset asserted during the acknowledge cycle.
    step();
    dbg_drive(1'b0, 32'h8, 32'h0);
    @(negedge clk);
    chk("rack_gnt", {31'b0, bus.mem_read}, 32'd1);
    step();
    rst_n = 1'b0;
    bus.dbg_req = 1'b0;
    @(negedge clk);
    chk("rack_in_ack", {31'b0, bus.dbg_ack}, 32'd1);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rack_ack_clr", {31'b0, bus.dbg_ack}, 32'd0);
    chk("rack_rdata_clr", bus.dbg_rdata, 32'd0);
    chk("rack_err_clr", {31'b0, bus.addr_err}, 32'd0);
    step();
    @(negedge clk);
    chk("rack_no_pulse", {31'b0, bus.dbg_ack}, 32'd0);

    // After reset the wait counter starts from zero: grant again at cycle 4.
    step();
    cpu_drive(1'b0, 32'h8, 32'h0);
    dbg_drive(1'b0, 32'h10, 32'h0);
    gnt_cyc = -1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus.cpu_stall && (gnt_cyc < 0)) gnt_cyc = k;
      step();
    end
    chk("post_rst_gnt_cycle", gnt_cyc, 32'd4);
    idle_all();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 32, meaning the number of words in the shared data memory.
REQ-002 The block SHALL have parameter DBG_MAX_WAIT, default 4, meaning the maximum number of cycles the debug port waits while the CPU holds the memory.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-005 The block SHALL have CPU-side ports: cpu_req (in, 1), cpu_we (in, 1), cpu_addr (in, 32), cpu_wdata (in, 32), cpu_rdata (out, 32), cpu_stall (out, 1).
REQ-006 The block SHALL have debug-side ports: dbg_req (in, 1), dbg_we (in, 1), dbg_addr (in, 32), dbg_wdata (in, 32), dbg_rdata (out, 32), dbg_ack (out, 1).
REQ-007 The block SHALL have memory-side ports: mem_addr (out, 32), mem_wdata (out, 32), mem_write (out, 1), mem_read (out, 1), mem_rdata (in, 32), with asynchronous memory read and writes taken on the clk edge.
REQ-008 The block SHALL have port addr_err, output, 1 bit: sticky flag for any misaligned or out-of-range request.

Function
REQ-009 The FSM SHALL have two states: S_IDLE and S_ACK; S_ACK SHALL last exactly one cycle and then return to S_IDLE.
REQ-010 In S_IDLE, dbg_gnt SHALL equal dbg_req && (!cpu_req || wait_cnt == DBG_MAX_WAIT); in S_ACK, dbg_gnt SHALL be 0 and dbg_req SHALL be ignored.
REQ-011 When dbg_gnt=1, the FSM SHALL go to S_ACK on the next edge.
REQ-012 cpu_stall SHALL be cpu_req && dbg_gnt (combinational, same cycle); otherwise a CPU request SHALL be served the same cycle.
REQ-013 The mem_* outputs SHALL be muxed from the debug port when dbg_gnt=1, from the CPU port when cpu_req && !dbg_gnt, and SHALL be mem_read=mem_write=0 otherwise.
REQ-014 While the CPU is served: mem_read = !cpu_we, mem_write = cpu_we, and cpu_rdata = mem_rdata combinationally; otherwise cpu_rdata SHALL hold its last served value.
REQ-015 wait_cnt (width clog2(DBG_MAX_WAIT+1)) SHALL increment when dbg_req && !dbg_gnt in S_IDLE, saturate at DBG_MAX_WAIT, and clear when dbg_gnt=1 or dbg_req=0.
REQ-016 On the edge ending a debug grant, dbg_rdata SHALL capture mem_rdata for reads and hold for writes; dbg_ack SHALL be 1 exactly in S_ACK.
REQ-017 A request is invalid when addr[1:0] != 0 or (addr>>2) >= DEPTH_WORDS; an invalid request SHALL suppress mem_write, SHALL still be granted/acked normally, SHALL return 0 as read data, and SHALL set addr_err on the next edge.
REQ-018 addr_err SHALL stay set until reset.
REQ-019 When cpu_req and dbg_req rise in the same cycle with wait_cnt=0, the CPU SHALL win; debug SHALL be served within DBG_MAX_WAIT+1 cycles under any CPU load.

Reset
REQ-020 While rst_n=0 at an edge, the block SHALL set state=S_IDLE, wait_cnt=0, dbg_ack=0, dbg_rdata=0, cpu_rdata hold register=0, and addr_err=0.
REQ-021 While rst_n=0, mem_write SHALL be forced to 0 combinationally.
REQ-022 A reset during S_ACK SHALL abort the acknowledgement, and no dbg_ack pulse SHALL follow the reset.

Structure
REQ-023 The FSM state encoding and the default parameter values SHALL live in shared package dmem_pkg.
REQ-024 The address-validity check SHALL be one sub-module, dmem_addr_chk, instantiated twice (once for CPU, once for debug).
REQ-025 The block SHALL instantiate no memory; it connects to the existing data memory through the mem_* ports.

Verification
REQ-026 CPU-only case: cpu_req=1, we=1, addr=0x8, wdata=0xDEADBEEF, then a read of 0x8 -> mem_write pulses one cycle, read returns 0xDEADBEEF the same cycle, and cpu_stall stays 0.
REQ-027 Idle CPU, debug read: dbg read of 0x8 -> dbg_gnt in cycle 0, dbg_ack=1 in cycle 1 with dbg_rdata=0xDEADBEEF, and a held dbg_req in cycle 1 is not regranted.
REQ-028 Starvation case: cpu_req held high and dbg_req raised at cycle 0 -> grant in cycle 4, cpu_stall=1 only in cycle 4, and dbg_ack in cycle 5.
REQ-029 Errors: CPU write to 0x6, then debug read of 0x80 (DEPTH 32) -> no mem_write, dbg_rdata=0, and addr_err=1 from the next cycle until rst_n=0.
REQ-030 Reset during S_ACK: rst_n=0 in the ack cycle -> dbg_ack=0 afterwards, state=S_IDLE, and wait_cnt=0.
